pc_update_unit: RTL and testbench

Fetch-stage program-counter register for the 32-bit pipeline. It sits directly downstream of the branch-offset shifter, consuming its ×4 output. It forms the branch target as PC+4 of the branch plus the shifted offset, or the jump target, and sequences the fetch PC through stalls and redirects. It drives the instruction-memory address and a one-cycle flush pulse to the IF/ID register.

---
 rtl/pc_update_unit.sv | 115 +++++++++++
 tb/tb_pc_update_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// Fetch-stage PC register: sequences the fetch address through stalls and branch/jump redirects.
// Optional delay-slot behaviour is enabled by defining DELAY_SLOT_EN.
module pc_update_unit #(
    parameter int unsigned         dataWidth = 32,
    parameter logic [dataWidth-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branchTaken,
    input  logic                 jump,
    input  logic [dataWidth-1:0] branchPcPlus4,
    input  logic [dataWidth-1:0] offsetShifted,
    input  logic [25:0]          jumpIndex,
    output logic [dataWidth-1:0] pcOut,
    output logic [dataWidth-1:0] pcPlus4Out,
    output logic [dataWidth-1:0] targetOut,
    output logic                 flushOut
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        SLOT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [dataWidth-1:0] pc_q, pc_d;
    logic [dataWidth-1:0] target_q, target_d;
    logic                 flush_q, flush_d;

    logic                 req;
    logic [dataWidth-1:0] br_target;
    logic [dataWidth-1:0] jmp_target;
    logic [dataWidth-1:0] new_target;
    logic [dataWidth-1:0] pc_plus4;

    assign req        = branchTaken | jump;
    assign br_target  = branchPcPlus4 + offsetShifted;
    assign jmp_target = {branchPcPlus4[dataWidth-1:28], jumpIndex, 2'b00};
    // Branch takes priority over jump when both are asserted.
    assign new_target = branchTaken ? br_target : jmp_target;
    assign pc_plus4   = pc_q + dataWidth'(4);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        flush_d  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (req) begin
                    target_d = new_target;
                    if (stall) begin
                        state_d = PEND;
                    end else begin
`ifdef DELAY_SLOT_EN
                        pc_d    = pc_plus4;
                        state_d = SLOT;
`else
                        pc_d    = new_target;
                        flush_d = 1'b1;
`endif
                    end
                end else if (!stall) begin
                    pc_d = pc_plus4;
                end
            end
            PEND: begin
                // First latched target wins; further requests are ignored here.
                if (!stall) begin
`ifdef DELAY_SLOT_EN
                    pc_d    = pc_plus4;
                    state_d = SLOT;
`else
                    pc_d    = target_q;
                    flush_d = 1'b1;
                    state_d = RUN;
`endif
                end
            end
            SLOT: begin
`ifdef DELAY_SLOT_EN
                if (!stall) begin
                    pc_d    = target_q;
                    state_d = RUN;
                end
`else
                state_d = RUN;
`endif
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            target_q <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            flush_q  <= flush_d;
        end
    end

    assign pcOut      = pc_q;
    assign pcPlus4Out = pc_plus4;
    assign targetOut  = target_q;
    assign flushOut   = flush_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench for pc_update_unit: directed vectors push expected state, a negedge monitor compares.
// Define DELAY_SLOT_EN for both RTL and bench to exercise the delay-slot variant.
module tb_pc_update_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branchTaken;
    logic        jump;
    logic [31:0] branchPcPlus4;
    logic [31:0] offsetShifted;
    logic [25:0] jumpIndex;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4Out;
    logic [31:0] targetOut;
    logic        flushOut;

    pc_update_unit #(
        .dataWidth(32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .jump         (jump),
        .branchPcPlus4(branchPcPlus4),
        .offsetShifted(offsetShifted),
        .jumpIndex    (jumpIndex),
        .pcOut        (pcOut),
        .pcPlus4Out   (pcPlus4Out),
        .targetOut    (targetOut),
        .flushOut     (flushOut)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        fl;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: every negedge with a pending expectation, compare registered outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".pc"},    pcOut,             e.pc);
            chk({e.name, ".pc4"},   pcPlus4Out,        e.pc + 32'd4);
            chk({e.name, ".tgt"},   targetOut,         e.tgt);
            chk({e.name, ".flush"}, {31'd0, flushOut}, {31'd0, e.fl});
        end
    end

    // Drive one cycle of inputs, push the hand-computed post-edge state, realign to negedge.
    task automatic step(input logic st, input logic br, input logic jp,
                        input logic [31:0] bp4, input logic [31:0] off, input logic [25:0] ji,
                        input logic [31:0] epc, input logic [31:0] etgt, input logic efl,
                        input string nm);
        exp_t e;
        stall         = st;
        branchTaken   = br;
        jump          = jp;
        branchPcPlus4 = bp4;
        offsetShifted = off;
        jumpIndex     = ji;
        @(posedge clk);
        e.pc   = epc;
        e.tgt  = etgt;
        e.fl   = efl;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] epc, input logic [31:0] etgt, input string nm);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, epc, etgt, 1'b0, nm);
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branchTaken   = 1'b0;
        jump          = 1'b0;
        branchPcPlus4 = '0;
        offsetShifted = '0;
        jumpIndex     = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.pc",    pcOut,             32'h0);
        chk("rst.pc4",   pcPlus4Out,        32'h4);
        chk("rst.tgt",   targetOut,         32'h0);
        chk("rst.flush", {31'd0, flushOut}, 32'h0);
        reset = 1'b0;

        idle(32'h4,  32'h0, "seq1");
        idle(32'h8,  32'h0, "seq2");
        idle(32'hC,  32'h0, "seq3");
        idle(32'h10, 32'h0, "seq4");

`ifdef DELAY_SLOT_EN
        idle(32'h14, 32'h0, "seq5");
        idle(32'h18, 32'h0, "seq6");
        idle(32'h1C, 32'h0, "seq7");
        idle(32'h20, 32'h0, "seq8");
        step(1'b0, 1'b1, 1'b0, 32'h24, 32'h5C, 26'h0, 32'h24, 32'h80, 1'b0, "ds_slot");
        idle(32'h80, 32'h80, "ds_tgt");
        idle(32'h84, 32'h80, "ds_after");
        step(1'b1, 1'b1, 1'b0, 32'h88, 32'h78, 26'h0, 32'h84, 32'h100, 1'b0, "ds_pend");
        idle(32'h88, 32'h100, "ds_pend_slot");
        step(1'b1, 1'b1, 1'b0, 32'h4F0, 32'h10, 26'h0, 32'h88, 32'h100, 1'b0, "ds_slot_stall");
        idle(32'h100, 32'h100, "ds_pend_tgt");
        idle(32'h104, 32'h100, "ds_end");
`else
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFF0, 26'h0, 32'hF0, 32'hF0, 1'b1, "br_neg");
        idle(32'hF4, 32'hF0, "br_neg_after");
        step(1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'h20, 26'h40,
             32'h8000_0030, 32'h8000_0030, 1'b1, "br_prio");
        step(1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h20, 26'h40,
             32'h8000_0100, 32'h8000_0100, 1'b1, "jump");
        idle(32'h8000_0104, 32'h8000_0100, "jump_after");
        step(1'b1, 1'b1, 1'b0, 32'h200, 32'h10, 26'h0, 32'h8000_0104, 32'h210, 1'b0, "pend_enter");
        step(1'b1, 1'b1, 1'b0, 32'h4F0, 32'h10, 26'h0, 32'h8000_0104, 32'h210, 1'b0, "pend_ignore");
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h8000_0104, 32'h210, 1'b0, "pend_hold");
        step(1'b0, 1'b1, 1'b0, 32'h4F0, 32'h10, 26'h0, 32'h210, 32'h210, 1'b1, "pend_resolve");
        idle(32'h214, 32'h210, "pend_after");
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h214, 32'h210, 1'b0, "stall_hold");
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h8, 26'h0, 32'h4, 32'h4, 1'b1, "wrap");
        idle(32'h8, 32'h4, "wrap_after");
        step(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 26'h0, 32'h8, 32'h300, 1'b0, "pend2_enter");

        // Asynchronous reset away from any clock edge while PEND holds a target.
        stall       = 1'b1;
        branchTaken = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst.pc",    pcOut,             32'h0);
        chk("arst.tgt",   targetOut,         32'h0);
        chk("arst.flush", {31'd0, flushOut}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(32'h4, 32'h0, "arst_drop");
        idle(32'h8, 32'h0, "arst_run");
`endif

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
